// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the RAM access controller:
//   - default RAM geometry (512 x 32) and read latency
//   - byte-enable width for masked stores
//   - controller state encoding (state_t) and latched operation kind (op_t)
// Optional feature macro: MEM_RMW_EN (adds the MERGE state for masked stores).
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int unsigned MC_ADDR_W       = 9;
  localparam int unsigned MC_DATA_W       = 32;
  localparam int unsigned MC_READ_LATENCY = 1;
  localparam int unsigned MC_BE_W         = 4;

  // Controller states. MERGE only exists when masked stores are supported.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef MEM_RMW_EN
    ST_MERGE = 3'd3,
`endif
    ST_RESP  = 3'd4
  } state_t;

  // What the accepted request turned into. OP_RMW / OP_NOP only arise for
  // masked stores (partial mask / empty mask).
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_RMW   = 2'd2,
    OP_NOP   = 2'd3
  } op_t;

  // A mask with every byte set is an ordinary full-word store.
  function automatic logic be_is_full(input logic [MC_BE_W-1:0] be);
    return &be;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_merge.sv
// -----------------------------------------------------------------------------
// byte_merge
// Combinational byte-lane merge for read-modify-write stores: every byte
// whose enable is set comes from the store data, every other byte keeps the
// value just read from the RAM.
// Ports:
//   wdata_i  [DATA_W-1:0]  store data
//   rdata_i  [DATA_W-1:0]  current RAM word
//   be_i     [BE_W-1:0]    byte enables (bit n covers bits 8n+7:8n)
//   merged_o [DATA_W-1:0]  word to write back
// -----------------------------------------------------------------------------
module byte_merge #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] merged_o
);

  always_comb begin
    merged_o = rdata_i;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be_i[b]) begin
        merged_o[b*8 +: 8] = wdata_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Initiator-side controller for a synchronous single-port RAM with a
// registered read. Takes one load/store at a time from the CPU control unit,
// strobes the RAM for exactly one cycle, waits out the read latency, captures
// the read data and returns a one-cycle completion pulse.
//
// Optional feature macro: MEM_RMW_EN
//   defined   : req_be port present; masked stores become read-modify-write
//               (full mask = plain store, empty mask = no RAM access)
//   undefined : no req_be port, every store is a full-word write
//
// Handshake: a request is taken on a clock edge where req_valid && req_ready.
// req_ready is high only in IDLE; a request presented while busy is ignored
// (not queued) and the requester must hold it until it is taken. The
// response (resp_valid) is a single-cycle pulse and cannot be stalled.
//
// Ports:
//   clock        single clock, rising edge
//   clear        synchronous active-high reset
//   req_valid    request present
//   req_ready    controller idle, can accept
//   req_write    1 = store, 0 = load
//   req_addr     word address
//   req_wdata    store data
//   req_be       byte enables (MEM_RMW_EN only)
//   resp_valid   one-cycle completion pulse
//   resp_rdata   last load data, held until the next load completes
//   Read/Write   RAM strobes, one cycle per access, never both high
//   address      RAM address, holds its last value between accesses
//   DataIn       RAM write data, holds its last value between accesses
//   DataOut      RAM registered read data
//   dbg_state_o  current controller state
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = MC_ADDR_W,
  parameter int unsigned DATA_W       = MC_DATA_W,
  parameter int unsigned READ_LATENCY = MC_READ_LATENCY  // must be >= 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_RMW_EN
  input  logic [MC_BE_W-1:0] req_be,
`endif
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              Read,
  output logic              Write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  output state_t            dbg_state_o
);

  // Counter holds READ_LATENCY down to 1; the WAIT cycle that sees 1 is the
  // cycle DataOut is valid.
  localparam int unsigned CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  state_t            state_q, state_d;
  op_t               op_q,    op_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] din_q,   din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef MEM_RMW_EN
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [MC_BE_W-1:0] be_q,    be_d;
  logic [DATA_W-1:0]  merged_word;

  byte_merge #(
    .DATA_W (DATA_W),
    .BE_W   (MC_BE_W)
  ) u_byte_merge (
    .wdata_i  (wdata_q),
    .rdata_i  (DataOut),
    .be_i     (be_q),
    .merged_o (merged_word)
  );
`endif

  // ---------------------------------------------------------------------------
  // Next-state and strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rdata_d    = rdata_q;
`ifdef MEM_RMW_EN
    wdata_d    = wdata_q;
    be_d       = be_q;
`endif
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    Read       = 1'b0;
    Write      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ST_ISSUE;
          addr_d  = req_addr;
          if (!req_write) begin
            op_d = OP_LOAD;
          end else begin
`ifdef MEM_RMW_EN
            wdata_d = req_wdata;
            be_d    = req_be;
            if (be_is_full(req_be)) begin
              op_d  = OP_STORE;
              din_d = req_wdata;
            end else if (req_be == '0) begin
              // Nothing to write: leave the RAM pins untouched.
              op_d   = OP_NOP;
              addr_d = addr_q;
            end else begin
              op_d = OP_RMW;
            end
`else
            op_d  = OP_STORE;
            din_d = req_wdata;
`endif
          end
        end
      end

      ST_ISSUE: begin
        case (op_q)
          OP_LOAD: begin
            Read    = 1'b1;
            cnt_d   = CNT_W'(READ_LATENCY);
            state_d = ST_WAIT;
          end
          OP_STORE: begin
            Write   = 1'b1;
            state_d = ST_RESP;
          end
`ifdef MEM_RMW_EN
          OP_RMW: begin
            Read    = 1'b1;
            cnt_d   = CNT_W'(READ_LATENCY);
            state_d = ST_WAIT;
          end
          OP_NOP: begin
            state_d = ST_RESP;
          end
`endif
          default: begin
            state_d = ST_RESP;
          end
        endcase
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
`ifdef MEM_RMW_EN
          if (op_q == OP_RMW) begin
            // Masked store: build the write-back word; load data register
            // keeps the result of the last real load.
            din_d   = merged_word;
            state_d = ST_MERGE;
          end else begin
`else
          begin
`endif
            rdata_d = DataOut;
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

`ifdef MEM_RMW_EN
      ST_MERGE: begin
        Write   = 1'b1;
        state_d = ST_RESP;
      end
`endif

      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_RMW_EN
      wdata_q <= '0;
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
`ifdef MEM_RMW_EN
      wdata_q <= wdata_d;
      be_q    <= be_d;
`endif
    end
  end

  assign address     = addr_q;
  assign DataIn      = din_q;
  assign resp_rdata  = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller for the synchronous single-port RAM (512 x 32, one-cycle registered read). Accepts one load/store at a time from the CPU control unit over a valid/ready handshake, drives the RAM's Read/Write/address/DataIn strobes, waits out the read latency, captures DataOut and returns a one-cycle response pulse. Sits between the datapath's memory-address/memory-data registers and the RAM instance.

## Interface
- ADDR_W, 9, RAM word-address width
- DATA_W, 32, data width
- READ_LATENCY, 1, cycles from Read-asserted edge to DataOut valid (≥1)
- clock  in  1  single clock, all state updates on posedge
- clear  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_be  in  4  byte enables (only with MEM_RMW_EN)
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  DATA_W  load data, held until next load completes
- Read  out  1  RAM read strobe
- Write  out  1  RAM write strobe
- address  out  ADDR_W  RAM address
- DataIn  out  DATA_W  RAM write data
- DataOut  in  DATA_W  RAM registered read data

## Operation
- States: IDLE, ISSUE, WAIT, MERGE (RMW only), RESP.
- Accept on edge where req_valid && req_ready; latch write/addr/wdata/be; go ISSUE.
- ISSUE: address=latched addr. Load: Read=1, go WAIT. Store: Write=1, DataIn=wdata, go RESP.
- WAIT: Read=0; down-counter loaded with READ_LATENCY; on counter expiry capture DataOut into resp_rdata, go RESP (or MERGE for RMW store).
- RESP: resp_valid=1 for exactly one cycle, go IDLE. No response back-pressure.
- Read and Write never both high; strobes high for exactly one cycle per access.
- address/DataIn hold last value when strobes low.
- req_valid while not ready: ignored, not queued; requester must hold.
- After clear: state IDLE, req_ready=1, Read=0, Write=0, address=0, DataIn=0, resp_valid=0, resp_rdata=0.
- clear mid-operation: abort immediately, no resp_valid for the in-flight request, strobes low the cycle after the clear edge; a RAM write already strobed is not undone.

## Timing
- Accept at edge E0. Load (READ_LATENCY=1): Read high cycle 1, capture at end of cycle 2, resp_valid cycle 3, req_ready cycle 4. Each extra latency cycle adds one.
- Store: Write high cycle 1, resp_valid cycle 2, req_ready cycle 3.
- Back-to-back: next accept no earlier than the IDLE cycle after RESP.

## Configuration
- MEM_RMW_EN defined: req_be port present. Store with be=4'hF: plain store. be=4'h0: no RAM access, ISSUE→RESP directly. Partial be: ISSUE (Read=1) → WAIT → MERGE (Write=1, DataIn = per-byte select of wdata where be set, else read data) → RESP; resp_rdata unchanged by RMW stores. Store RMW latency = load latency + 1.
- Undefined: no req_be port, no MERGE state, all stores full-word.

## Structure
- Package mem_ctrl_pkg: state enum, default ADDR_W/DATA_W/READ_LATENCY constants, byte-enable width.
- Sub-module byte_merge (combinational, wdata/rdata/be → merged word), instantiated only under MEM_RMW_EN.
- FSM, latency counter and request latch in mem_access_ctrl.

## Test plan
- Store 32'hDEADBEEF to 9'h010 → Write high one cycle with address 9'h010, resp_valid at cycle 2, req_ready back at cycle 3.
- Load 9'h010 after that store → Read high cycle 1, resp_valid cycle 3 with resp_rdata=32'hDEADBEEF; Read/Write never overlap.
- Hold req_valid during busy with a second load of 9'h1FF → accepted only in next IDLE; returns correct data; address 9'h1FF (wrap limit) hits last word.
- READ_LATENCY=3 load → resp_valid at cycle 5, data captured from DataOut at correct cycle.
- clear asserted in WAIT → no resp_valid, all outputs reset values next cycle, req_ready=1.
- MEM_RMW_EN: word 32'h11223344, store 32'hAABBCCDD be=4'b0101 → RAM ends 32'h11BB33DD, resp_valid at cycle 4; be=4'h0 → no strobes, resp_valid cycle 2.
